// File: rtl/stack_pkg.sv
// stack_pkg: shared op encodings, FSM state type and default sizes for stack_arbiter
package stack_pkg;
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP = 1'b1;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_REQ = 4;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
//   req       in   N   request vector
//   ptr       in   IW  highest-priority index
//   grant     out  N   one-hot winner (0 when no request)
//   grant_idx out  IW  winner index
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);
    // Scan from the farthest offset down so the nearest request to ptr is written last.
    always_comb begin
        grant = '0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = N'(1) << ((int'(ptr) + k) % N);
                grant_idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin serialiser of push/pop transactions onto one shared LIFO stack
//   req_valid/req_op/req_data/req_ready  per-requester transaction handshake
//   resp_valid/resp_ready/resp_id/resp_op/resp_data/resp_err  tagged response
//   stk_in/stk_wn/stk_rn  stack strobes; stk_top/stk_full/stk_empty  stack status
//   busy  high outside IDLE
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic                          resp_op,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic [DATA_WIDTH-1:0]         stk_in,
    output logic                          stk_wn,
    output logic                          stk_rn,
    input  logic [DATA_WIDTH-1:0]         stk_top,
    input  logic                          stk_full,
    input  logic                          stk_empty,
    output logic                          busy
);
    state_t state_q, state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic op_q, op_d, err_q, err_d, exec, push_ok, pop_ok;
    logic [DATA_WIDTH-1:0] data_q, data_d, rdata_q, rdata_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .grant(grant),
        .grant_idx(grant_idx)
    );

    // Strobes derive from the state flop so an async reset kills them immediately.
    assign exec = state_q == EXEC;
    assign push_ok = exec && op_q == OP_PUSH && !stk_full;
    assign pop_ok = exec && op_q == OP_POP && !stk_empty;
    assign stk_wn = push_ok;
    assign stk_rn = pop_ok;
    assign stk_in = push_ok ? data_q : '0;
    assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
    assign resp_valid = state_q == RESP;
    assign busy = state_q != IDLE;
    assign resp_id = id_q;
    assign resp_op = op_q;
    assign resp_data = rdata_q;
    assign resp_err = err_q;

    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d = id_q;
        op_d = op_q;
        data_d = data_q;
        err_d = err_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && |req_valid) begin
            state_d = EXEC;
            rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            id_d = grant_idx;
            op_d = req_op[grant_idx];
            data_d = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (exec) begin
            state_d = RESP;
            err_d = op_q == OP_POP ? stk_empty : stk_full;
            rdata_d = pop_ok ? stk_top : '0;
        end else if (state_q == RESP && resp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            id_q <= '0;
            op_q <= 1'b0;
            data_q <= '0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q <= id_d;
            op_q <= op_d;
            data_q <= data_d;
            err_q <= err_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: randomized scoreboard bench for stack_arbiter with a 4-deep stack model
module tb_stack_arbiter;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0] req_valid = '0, req_op = '0, req_ready;
    logic [NR*DW-1:0] req_data = '0;
    logic resp_valid, resp_ready = 1'b1, resp_op, resp_err, stk_wn, stk_rn, stk_full, stk_empty, busy;
    logic [1:0] resp_id;
    logic [DW-1:0] resp_data, stk_in, stk_top;

    stack_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_op(resp_op),
        .resp_data(resp_data), .resp_err(resp_err),
        .stk_in(stk_in), .stk_wn(stk_wn), .stk_rn(stk_rn),
        .stk_top(stk_top), .stk_full(stk_full), .stk_empty(stk_empty), .busy(busy)
    );

    always #5 clk = ~clk;

    // Environment stack the DUT drives.
    logic [DW-1:0] mem [DEPTH];
    int cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 0;
        else if (stk_wn && cnt < DEPTH) begin
            mem[cnt] <= stk_in;
            cnt <= cnt + 1;
        end else if (stk_rn && cnt > 0) cnt <= cnt - 1;
    end
    assign stk_top = cnt > 0 ? mem[cnt-1] : '0;
    assign stk_full = cnt == DEPTH;
    assign stk_empty = cnt == 0;

    // Reference model and scoreboard.
    typedef struct {
        int id;
        logic op;
        logic err;
        logic [DW-1:0] data;
        logic [DW-1:0] wdata;
    } exp_t;
    exp_t q[$];
    exp_t e;
    logic [DW-1:0] mstk[$];
    int checks = 0, errors = 0;
    bit idle = 1'b1;
    int ptr = 0, cyc = 0, win;
    logic [NR-1:0] eg;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs", {req_ready, resp_valid, resp_id, resp_op, resp_data, resp_err,
                                  stk_in, stk_wn, stk_rn, busy}, '0);
            q.delete();
            mstk.delete();
            idle = 1'b1;
            ptr = 0;
            cyc = 0;
        end else if (idle) begin
            win = -1;
            for (int k = 0; k < NR; k++)
                if (win < 0 && req_valid[(ptr + k) % NR]) win = (ptr + k) % NR;
            eg = win < 0 ? '0 : NR'(1 << win);
            chk("grant", req_ready, eg);
            chk("idle_status", {busy, resp_valid, stk_wn, stk_rn}, '0);
            if (win >= 0) begin
                e.id = win;
                e.op = req_op[win];
                e.err = 1'b0;
                e.data = '0;
                e.wdata = req_data[win*DW +: DW];
                if (e.op == 1'b0) begin
                    if (mstk.size() == DEPTH) e.err = 1'b1;
                    else mstk.push_back(e.wdata);
                end else begin
                    if (mstk.size() == 0) e.err = 1'b1;
                    else e.data = mstk.pop_back();
                end
                q.push_back(e);
                ptr = (win + 1) % NR;
                idle = 1'b0;
                cyc = 0;
            end
        end else begin
            cyc++;
            e = q[0];
            chk("busy_noready", {busy, req_ready}, {1'b1, {NR{1'b0}}});
            chk("resp_valid", resp_valid, cyc >= 2);
            chk("stk_wn", stk_wn, cyc == 1 && e.op == 1'b0 && !e.err);
            chk("stk_rn", stk_rn, cyc == 1 && e.op == 1'b1 && !e.err);
            if (stk_wn) chk("stk_in", stk_in, e.wdata);
            if (resp_valid) begin
                chk("resp", {resp_id, resp_op, resp_err, resp_data}, {2'(e.id), e.op, e.err, e.data});
                if (resp_ready) begin
                    void'(q.pop_front());
                    idle = 1'b1;
                end
            end
        end
    end

    // Driver: holds each request until accepted; rmode 0 random, 1 ready high, 2 ready low.
    task automatic step(input int p_new, input int rmode);
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) req_valid[i] = 1'b0;
            if (!req_valid[i] && $urandom_range(0, 99) < p_new) begin
                req_valid[i] = 1'b1;
                req_op[i] = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
        resp_ready = rmode == 0 ? ($urandom_range(0, 3) != 0) : rmode == 1;
    endtask

    task automatic issue(input int id, input logic op, input logic [DW-1:0] d);
        req_valid[id] = 1'b1;
        req_op[id] = op;
        req_data[id*DW +: DW] = d;
        repeat (4) step(0, 1);
    endtask

    bit hit;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(0, 1'b0, 16'hA5A5);
        issue(2, 1'b0, 16'h1111);
        issue(2, 1'b1, 16'h0000);
        issue(3, 1'b1, 16'h0000);
        issue(3, 1'b1, 16'h0000);
        for (int n = 0; n < DEPTH + 1; n++) issue(1, 1'b0, DW'(16'h2000 + n));
        repeat (20) step(100, 1);
        req_valid = '0;
        repeat (6) step(0, 1);
        req_valid = 4'b0011;
        repeat (7) step(0, 2);
        repeat (8) step(0, 1);
        repeat (1500) step(30, 0);
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            step(30, 0);
            if (stk_wn) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        if (!hit) begin
            $display("FAIL rst_search: saw no push strobe within 300 cycles, expected one");
            $fatal(1, "no push strobe to reset during");
        end
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 4'b1111;
        repeat (12) step(100, 1);
        req_valid = '0;
        repeat (6) step(0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Round-robin controller that shares one LIFO stack instance among NUM_REQ requesters. Each requester issues push or pop transactions over a valid/ready handshake. The arbiter serialises them onto the stack's single write/read strobe port and returns one response per transaction, tagged with the requester ID. It sits between client engines and the stack. It is the only block allowed to drive the stack's strobes.

## Interface
- DATA_WIDTH, 16, width of pushed/popped data
- NUM_REQ, 4, number of requesters (≥2)
- ID_WIDTH, $clog2(NUM_REQ), derived localparam, not overridable

- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester transaction valid
- req_op  in  NUM_REQ  per-requester op: 0 = push, 1 = pop
- req_data  in  NUM_REQ*DATA_WIDTH  push data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept; transfer when valid & ready
- resp_valid  out  1  response valid, held until accepted
- resp_ready  in  1  response consumer ready
- resp_id  out  ID_WIDTH  requester index of the response
- resp_op  out  1  echoed op
- resp_data  out  DATA_WIDTH  popped data; 0 for push or error
- resp_err  out  1  push-on-full or pop-on-empty, stack untouched
- stk_in  out  DATA_WIDTH  data to stack
- stk_wn  out  1  push strobe, one cycle
- stk_rn  out  1  pop strobe, one cycle
- stk_top  in  DATA_WIDTH  current top-of-stack, combinational from stack
- stk_full  in  1  stack full
- stk_empty  in  1  stack empty
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick a winner round-robin starting at rr_ptr and assert req_ready for the winner only.
  - On the clock edge: latch id, op and data; set rr_ptr = (winner+1) mod NUM_REQ; go to EXEC.
  - If no req_valid is high, req_ready = 0 and rr_ptr holds.
- EXEC (exactly one cycle):
  - Push with !stk_full: stk_wn=1 and stk_in=latched data; resp_err=0 and resp_data=0.
  - Push with stk_full: no strobe; resp_err=1.
  - Pop with !stk_empty: stk_rn=1; register stk_top into resp_data in the same cycle; resp_err=0.
  - Pop with stk_empty: no strobe; resp_err=1 and resp_data=0.
  - Next state: RESP.
- RESP:
  - resp_valid=1; resp_id, resp_op, resp_data and resp_err are stable.
  - On resp_valid & resp_ready, go to IDLE. Otherwise hold.
- Only one transaction is in flight. req_ready is 0 in EXEC and RESP.
- stk_wn and stk_rn are never high together, and are never high outside EXEC.
- Requesters must hold req_valid, req_op and req_data stable until accepted. The arbiter does not check this.

## Timing
- Reset values: state IDLE, rr_ptr 0, all outputs 0 (req_ready, resp_*, stk_*, busy).
- Latency: accept at edge T; strobe during cycle T+1; resp_valid high from T+2.
  - With resp_ready held high, the next accept is in cycle T+3, so throughput is 1 transaction per 3 cycles.
- Round-robin wrap: after grant NUM_REQ-1, rr_ptr = 0.
  - A requester holding valid is granted within NUM_REQ transactions.
- Simultaneous valids: the lowest index ≥ rr_ptr (circularly) wins. The rest keep waiting with ready=0.
- A requester dropping valid in IDLE before the grant edge is simply not selected.
- stk_full and stk_empty are sampled only in EXEC.
- Reset mid-operation (EXEC or RESP):
  - Immediately clears every output, including any strobe in progress.
  - The in-flight transaction is dropped without a response.
  - Stack contents are the stack's own concern.
- resp_ready stuck low: stay in RESP indefinitely; no new grants.

## Structure
- Shared package stack_pkg:
  - Op encodings OP_PUSH=1'b0 and OP_POP=1'b1.
  - FSM state enum (IDLE, EXEC, RESP, 2-bit).
  - Default DATA_WIDTH and NUM_REQ constants.
- One natural sub-module: rr_arbiter (parameter N; inputs req[N], ptr; output one-hot grant[N] and grant_idx). This is purely combinational, and rr_ptr lives in stack_arbiter.
- Integration instantiates stack_arbiter alongside one stack.

## Test plan
- Reset, then requester 0 pushes 16'hA5A5 on an empty stack:
  - req_ready[0] pulses in cycle 0; stk_wn=1 with stk_in=A5A5 in cycle 1.
  - Cycle 2: resp_valid with id=0, op=0, err=0, data=0.
- Push 16'h1111 then pop, both from requester 2:
  - Pop response has data=16'h1111, err=0, and stk_rn pulses exactly once.
- All 4 requesters hold valid continuously, with resp_ready=1:
  - Grant order is 0,1,2,3,0,1.
  - One accept every 3 cycles; stk_wn and stk_rn are never high together.
- Pop with stk_empty=1:
  - No stk_rn; response err=1, data=0.
  - Push with stk_full=1: no stk_wn; err=1.
- resp_ready held low for 5 cycles with requester 1 valid:
  - resp_* stay stable and req_ready stays 0.
  - The grant to requester 1 occurs in the cycle after the response handshake.
- Assert rst during EXEC of a push:
  - stk_wn drops the same cycle and all outputs return to 0.
  - After release, rr_ptr=0 and requester 0 wins the next contention.
